frag_interp_scheduler: RTL and testbench



---
 rtl/frag_sched_pkg.sv | 33 +++
 rtl/frag_interp_scheduler_rr_arbiter.sv | 35 +++
 rtl/frag_interp_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_frag_interp_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frag_sched_pkg.sv
// Shared types and helpers for the fragment-interpolator scheduler.
package frag_sched_pkg;

  localparam int P_WIDTH = 66;

  typedef enum logic [1:0] {
    U_FREE     = 2'b00,
    U_BUSY     = 2'b01,
    U_COMPLETE = 2'b11
  } unit_state_t;

  // Returns {found, index} of the first set request bit at or after ptr,
  // wrapping modulo n (n <= 8, ptr < n).
  function automatic logic [3:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic       found;
    logic [2:0] idx;
    logic [3:0] pos;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pos = {1'b0, ptr} + 4'(i);
      if (pos >= 4'(n)) pos = pos - 4'(n);
      if (!found && (i < n) && req[pos[2:0]]) begin
        found = 1'b1;
        idx   = pos[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/frag_interp_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter
  import frag_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx,
  output logic         grant_valid
);

  logic [7:0] req_ext;
  logic [3:0] pick;

  // Zero-extend the request vector to the helper's fixed width.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign pick        = rr_next(req_ext, ptr, N);
  assign grant_valid = pick[3];
  assign grant_idx   = pick[2:0];

  // One-hot form of the granted index.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant[i] = grant_valid && (grant_idx == 3'(i));
    end
  end

endmodule

// File: rtl/frag_interp_scheduler.sv
// Sample-point scheduler feeding NUM_UNITS fragment interpolators.
// Optional build macro FRAG_SCHED_PERF_EN adds saturating perf counters.
module frag_interp_scheduler
  import frag_sched_pkg::*;
#(
  parameter int NUM_UNITS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [P_WIDTH-1:0]             in_P,
  input  logic                           flush,
  output logic [NUM_UNITS-1:0]           unit_start,
  output logic [P_WIDTH*NUM_UNITS-1:0]   unit_P,
  input  logic [NUM_UNITS-1:0]           unit_ready,
  input  logic [NUM_UNITS-1:0]           unit_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2:0]                     out_unit,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic                           busy
`ifdef FRAG_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_dispatched,
  output logic [31:0]                    perf_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = P_WIDTH + TAG_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, count_next;
  logic [TAG_WIDTH-1:0] tag_cnt;
  logic                 in_ready_q;
  logic                 push, pop, fifo_nonempty;
  logic [P_WIDTH-1:0]   head_p;
  logic [TAG_WIDTH-1:0] head_tag;

  unit_state_t          ustate [NUM_UNITS];
  logic [TAG_WIDTH-1:0] utag   [NUM_UNITS];
  logic [P_WIDTH-1:0]   up     [NUM_UNITS];

  logic [NUM_UNITS-1:0] disp_req, disp_grant;
  logic [2:0]           disp_idx, disp_ptr;
  logic                 disp_valid, disp_fire;

  logic [NUM_UNITS-1:0] cpl_req, cpl_grant, sel_onehot;
  logic [2:0]           cpl_idx, cpl_ptr, hold_idx;
  logic                 cpl_valid, hold_valid, accept;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    return (idx == 3'(NUM_UNITS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  assign in_ready      = in_ready_q && !reset;
  assign push          = in_valid && in_ready && !flush;
  assign fifo_nonempty = (count != '0);
  assign disp_fire     = disp_valid && fifo_nonempty && !flush;
  assign pop           = disp_fire;
  assign head_p        = fifo_mem[rd_ptr][EW-1:TAG_WIDTH];
  assign head_tag      = fifo_mem[rd_ptr][TAG_WIDTH-1:0];
  assign count_next    = count + CW'(push) - CW'(pop);

  // FIFO pointers, occupancy, registered in_ready and the tag counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      tag_cnt    <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + TAG_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      in_ready_q <= (count_next != FULL_CNT);
    end
  end

  // FIFO storage; entries need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_P, tag_cnt};
  end

  // Request vectors for the two arbiters.
  always_comb begin
    disp_req = '0;
    cpl_req  = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      disp_req[i] = (ustate[i] == U_FREE) && unit_ready[i];
      cpl_req[i]  = (ustate[i] == U_COMPLETE);
    end
  end

  rr_arbiter #(.N(NUM_UNITS)) u_disp_arb (
    .req         (disp_req),
    .ptr         (disp_ptr),
    .grant       (disp_grant),
    .grant_idx   (disp_idx),
    .grant_valid (disp_valid)
  );

  rr_arbiter #(.N(NUM_UNITS)) u_cpl_arb (
    .req         (cpl_req),
    .ptr         (cpl_ptr),
    .grant       (cpl_grant),
    .grant_idx   (cpl_idx),
    .grant_valid (cpl_valid)
  );

  // A stalled completion keeps its unit locked so a later done elsewhere
  // cannot change out_unit/out_tag before the handshake.
  always_comb begin
    sel_onehot = '0;
    out_tag    = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      sel_onehot[i] = hold_valid ? (hold_idx == 3'(i)) : cpl_grant[i];
      if (out_valid && sel_onehot[i]) out_tag = utag[i];
    end
  end

  assign out_valid = cpl_valid;
  assign out_unit  = out_valid ? (hold_valid ? hold_idx : cpl_idx) : '0;
  assign accept    = out_valid && out_ready;

  // Completion lock and completion round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_idx   <= '0;
      cpl_ptr    <= '0;
    end else begin
      hold_valid <= out_valid && !out_ready;
      hold_idx   <= out_unit;
      if (accept) cpl_ptr <= wrap_inc(out_unit);
    end
  end

  // Per-unit state, latched point/tag, start pulse and dispatch pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        ustate[i] <= U_FREE;
        utag[i]   <= '0;
        up[i]     <= '0;
      end
      unit_start <= '0;
      disp_ptr   <= '0;
    end else begin
      unit_start <= disp_fire ? disp_grant : '0;
      if (disp_fire) disp_ptr <= wrap_inc(disp_idx);
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        case (ustate[i])
          U_FREE: begin
            if (disp_fire && disp_grant[i]) begin
              ustate[i] <= U_BUSY;
              utag[i]   <= head_tag;
              up[i]     <= head_p;
            end
          end
          U_BUSY:     if (unit_done[i]) ustate[i] <= U_COMPLETE;
          U_COMPLETE: if (accept && sel_onehot[i]) ustate[i] <= U_FREE;
          default:    ustate[i] <= U_FREE;
        endcase
      end
    end
  end

  // Flatten per-unit points and summarise activity.
  always_comb begin
    unit_P = '0;
    busy   = fifo_nonempty || (|unit_start);
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      unit_P[i*P_WIDTH +: P_WIDTH] = up[i];
      if (ustate[i] != U_FREE) busy = 1'b1;
    end
  end

`ifdef FRAG_SCHED_PERF_EN
  // Saturating counters for start pulses and stalled-with-work cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dispatched <= '0;
      perf_stall      <= '0;
    end else begin
      if ((|unit_start) && (perf_dispatched != '1))
        perf_dispatched <= perf_dispatched + 32'd1;
      if (fifo_nonempty && !(|disp_req) && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_frag_interp_scheduler.sv
// Scoreboard bench for frag_interp_scheduler (NUM_UNITS=2, FIFO_DEPTH=4).
module tb_frag_interp_scheduler;

  localparam int NU = 2;
  localparam int PW = 66;
  localparam int TW = 8;

  typedef struct { int unit; logic [65:0] p; } start_t;
  typedef struct { int unit; int tag; } cpl_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PW-1:0]     in_P = '0;
  logic              flush = 1'b0;
  logic [NU-1:0]     unit_start;
  logic [PW*NU-1:0]  unit_P;
  logic [NU-1:0]     unit_ready = '0;
  logic [NU-1:0]     unit_done = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        out_unit;
  logic [TW-1:0]     out_tag;
  logic              busy;
`ifdef FRAG_SCHED_PERF_EN
  logic [31:0]       perf_dispatched;
  logic [31:0]       perf_stall;
`endif

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  start_t exp_start[$];
  cpl_t   exp_cpl[$];

  always #5 clk = ~clk;

  frag_interp_scheduler #(.NUM_UNITS(NU), .FIFO_DEPTH(4), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_P       (in_P),
    .flush      (flush),
    .unit_start (unit_start),
    .unit_P     (unit_P),
    .unit_ready (unit_ready),
    .unit_done  (unit_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_unit   (out_unit),
    .out_tag    (out_tag),
    .busy       (busy)
`ifdef FRAG_SCHED_PERF_EN
    ,
    .perf_dispatched (perf_dispatched),
    .perf_stall      (perf_stall)
`endif
  );

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [65:0] pt(input int k);
    return {2'b10, 32'hC0DE_0000 + 32'(k), 32'(k) ^ 32'h5A5A_5A5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected starts/completions when the DUT presents them.
  initial begin
    start_t es;
    cpl_t ec;
    logic prev_hold;
    logic [2:0] hold_unit;
    logic [TW-1:0] hold_tag;
    prev_hold = 1'b0;
    hold_unit = '0;
    hold_tag = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (unit_start != '0) begin
          if (exp_start.size() == 0) begin
            chk("start_unexpected", 66'(unit_start), 66'(0));
          end else begin
            es = exp_start.pop_front();
            chk("start_unit", 66'(unit_start), 66'(1 << es.unit));
            chk("start_P", unit_P[es.unit*PW +: PW], es.p);
          end
        end
        if (prev_hold) begin
          chk("hold_valid", 66'(out_valid), 66'(1));
          chk("hold_unit", 66'(out_unit), 66'(hold_unit));
          chk("hold_tag", 66'(out_tag), 66'(hold_tag));
        end
        if (out_valid && out_ready) begin
          acc_cnt++;
          if (exp_cpl.size() == 0) begin
            chk("cpl_unexpected", 66'(out_valid), 66'(0));
          end else begin
            ec = exp_cpl.pop_front();
            chk("cpl_unit", 66'(out_unit), 66'(ec.unit));
            chk("cpl_tag", 66'(out_tag), 66'(ec.tag));
          end
        end
        prev_hold = out_valid && !out_ready;
        hold_unit = out_unit;
        hold_tag = out_tag;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_pt(input logic [65:0] p);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_P = p;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    chk("push_accept", 66'(ok), 66'(1));
    tick();
  endtask

  task automatic wait_start(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_start.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 66'(exp_start.size()), 66'(0));
    tick();
  endtask

  task automatic wait_cpl(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_cpl.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 66'(exp_cpl.size()), 66'(0));
    tick();
  endtask

  task automatic do_reset();
    chk("sb_start_empty", 66'(exp_start.size()), 66'(0));
    chk("sb_cpl_empty", 66'(exp_cpl.size()), 66'(0));
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    unit_done = '0;
    tick();
    @(negedge clk);
    chk("in_ready_in_reset", 66'(in_ready), 66'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 66'(in_ready), 66'(1));
    chk("rst_unit_start", 66'(unit_start), 66'(0));
    chk("rst_unit_P", 66'(unit_P[PW-1:0] | unit_P[2*PW-1:PW]), 66'(0));
    chk("rst_out_valid", 66'(out_valid), 66'(0));
    chk("rst_out_unit", 66'(out_unit), 66'(0));
    chk("rst_out_tag", 66'(out_tag), 66'(0));
    chk("rst_busy", 66'(busy), 66'(0));
    tick();
  endtask

  initial begin
    int n0;

    // Round-robin dispatch, out-of-order completion, stalled output.
    do_reset();
    unit_ready = 2'b11;
    out_ready = 1'b1;
    exp_start.push_back('{0, pt(0)});
    exp_start.push_back('{1, pt(1)});
    push_pt(pt(0));
    push_pt(pt(1));
    push_pt(pt(2));
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    chk("busy_with_queued", 66'(busy), 66'(1));
    chk("first_two_starts", 66'(exp_start.size()), 66'(0));
    tick();
    exp_start.push_back('{1, pt(2)});
    exp_cpl.push_back('{1, 1});
    unit_done = 2'b10;
    tick();
    unit_done = '0;
    wait_cpl("cpl_u1_first", 6);
    wait_start("dispatch_p2_u1", 6);

    exp_cpl.push_back('{0, 0});
    exp_cpl.push_back('{1, 2});
    out_ready = 1'b0;
    unit_done = 2'b11;
    tick();
    unit_done = '0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    chk("stall_valid", 66'(out_valid), 66'(1));
    chk("stall_unit", 66'(out_unit), 66'(0));
    chk("stall_tag", 66'(out_tag), 66'(0));
    tick();
    n0 = acc_cnt;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("two_cpl_back_to_back", 66'(acc_cnt - n0), 66'(2));
    chk("cpl_queue_drained", 66'(exp_cpl.size()), 66'(0));
    tick();
    unit_done = 2'b11;
    tick();
    unit_done = '0;
    @(negedge clk);
    #1;
    chk("done_while_free_ignored", 66'(out_valid), 66'(0));
    chk("idle_not_busy", 66'(busy), 66'(0));
    tick();

    // FIFO full back-pressure, no bypass, then reset mid-operation.
    do_reset();
    unit_ready = 2'b00;
    for (int k = 0; k < 4; k++) push_pt(pt(10 + k));
    in_valid = 1'b1;
    in_P = pt(14);
    @(negedge clk);
    chk("in_ready_full", 66'(in_ready), 66'(0));
    tick();
    unit_ready = 2'b01;
    exp_start.push_back('{0, pt(10)});
    @(negedge clk);
    chk("in_ready_no_bypass", 66'(in_ready), 66'(0));
    push_pt(pt(14));
    in_valid = 1'b0;
    chk("start_before_fifth", 66'(exp_start.size()), 66'(0));
    @(negedge clk);
    chk("busy_before_reset", 66'(busy), 66'(1));
    tick();
    do_reset();

    // Flush drops FIFO contents and a same-cycle push; tag counter kept.
    unit_ready = 2'b00;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_pt(pt(20 + k));
    in_P = pt(29);
    in_valid = 1'b1;
    flush = 1'b1;
    unit_ready = 2'b01;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #1;
    chk("flush_empties", 66'(busy), 66'(0));
    tick();
    exp_start.push_back('{0, pt(23)});
    exp_cpl.push_back('{0, 3});
    push_pt(pt(23));
    in_valid = 1'b0;
    wait_start("post_flush_start", 6);
    unit_done = 2'b01;
    tick();
    unit_done = '0;
    wait_cpl("post_flush_tag3", 6);

    // 257 single-point transactions: units alternate, tag wraps to 0.
    do_reset();
    unit_ready = 2'b11;
    out_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      exp_start.push_back('{k % 2, pt(1000 + k)});
      exp_cpl.push_back('{k % 2, k % 256});
      push_pt(pt(1000 + k));
      in_valid = 1'b0;
      wait_start("rr_start", 6);
      unit_done = NU'(1 << (k % 2));
      tick();
      unit_done = '0;
      wait_cpl("rr_cpl", 6);
    end
    @(negedge clk);
    chk("drain_not_busy", 66'(busy), 66'(0));
`ifdef FRAG_SCHED_PERF_EN
    chk("perf_dispatched", 66'(perf_dispatched), 66'(257));
`endif
    tick();

    chk("final_start_empty", 66'(exp_start.size()), 66'(0));
    chk("final_cpl_empty", 66'(exp_cpl.size()), 66'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
